// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that merges NUM_REQ beat streams into
// the write side of one FIFO. A grant lasts up to MAX_BURST beats. It also ends
// early when the granted requester drops valid. Arbitration takes one idle
// cycle between bursts.
// Optional feature: define FIFO_WR_ARB_CNT_EN to add the per-requester
// saturating accepted-beat counters on output beat_cnt.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            wr_clk,
    input  logic                            aclr,
    input  logic                            sclr,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wrreq,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
`ifdef FIFO_WR_ARB_CNT_EN
    output logic [NUM_REQ*16-1:0]           beat_cnt,
`endif
    output logic                            busy
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int GWP = GW + 1;
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [7:0]      burst_cnt_reg;

    logic            cur_valid;
    logic            accept_ok;
    logic [GW-1:0]   search_base;
    logic [GW-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;
    logic [NUM_REQ-1:0] first_hit;
    logic [NUM_REQ-1:0] sel_bits [GW];
    logic [GW-1:0]   pick_idx;
    logic [DATA_WIDTH-1:0] data_lane [NUM_REQ];

    // Round-robin search starts one past the previous grantee.
    assign search_base = (last_grant_reg == GW'(NUM_REQ - 1)) ? '0 : last_grant_reg + GW'(1);

    // Candidate gi is the requester gi positions after search_base (mod NUM_REQ).
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [GWP-1:0] cand_sum;
        assign cand_sum      = {1'b0, search_base} + GWP'(gi);
        assign cand_idx[gi]  = (cand_sum >= GWP'(NUM_REQ)) ? GW'(cand_sum - GWP'(NUM_REQ))
                                                          : cand_sum[GW-1:0];
        assign cand_hit[gi]  = req_valid[cand_idx[gi]];
        assign data_lane[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lowest set bit of cand_hit = nearest valid requester in search order.
    assign first_hit = cand_hit & (~cand_hit + NUM_REQ'(1));

    // One-hot to index: OR together the candidate indices selected by first_hit.
    for (genvar gb = 0; gb < GW; gb++) begin : g_pick_bit
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick_req
            assign sel_bits[gb][gi] = first_hit[gi] & cand_idx[gi][gb];
        end
        assign pick_idx[gb] = |sel_bits[gb];
    end

    assign cur_valid = req_valid[grant_reg];
    // A beat can only be taken in a burst, with FIFO room, and never during sclr.
    assign accept_ok = (state_reg == ST_BURST) && !fifo_full && !sclr;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = accept_ok && (grant_reg == GW'(gi));
    end

    assign fifo_wrreq = accept_ok && cur_valid;
    assign fifo_data  = data_lane[grant_reg];
    assign grant_id   = grant_reg;
    assign busy       = (state_reg == ST_BURST);

    // Burst control: arbitrate in IDLE, count beats in BURST, hold on full.
    always_ff @(posedge wr_clk or posedge aclr) begin
        if (aclr) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            burst_cnt_reg  <= '0;
        end else if (sclr) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            burst_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if ((|req_valid) && !fifo_full) begin
                        state_reg     <= ST_BURST;
                        grant_reg     <= pick_idx;
                        burst_cnt_reg <= '0;
                    end
                end
                ST_BURST: begin
                    if (!cur_valid) begin
                        // Grantee went away: end the burst even if stalled.
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= grant_reg;
                    end else if (!fifo_full) begin
                        burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        if (burst_cnt_reg == LAST_BEAT) begin
                            state_reg      <= ST_IDLE;
                            last_grant_reg <= grant_reg;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_CNT_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [15:0] cnt_reg;

        // Count beats accepted from requester gi, sticking at all-ones.
        always_ff @(posedge wr_clk or posedge aclr) begin
            if (aclr) begin
                cnt_reg <= '0;
            end else if (sclr) begin
                cnt_reg <= '0;
            end else if (req_ready[gi] && req_valid[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end

        assign beat_cnt[gi*16 +: 16] = cnt_reg;
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, beat width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..255).
REQ-004 SHALL have port wr_clk, input, 1, sole clock; all state rising-edge.
REQ-005 SHALL have port aclr, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port sclr, input, 1, synchronous clear, active-high.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester beat accepted when valid&ready.
REQ-010 SHALL have port fifo_full, input, 1, full flag from the downstream FIFO write side.
REQ-011 SHALL have port fifo_wrreq, output, 1, write request to the FIFO.
REQ-012 SHALL have port fifo_data, output, DATA_WIDTH, write data to the FIFO.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ), registered index of the current/last grantee.
REQ-014 SHALL have port busy, output, 1, high while in state BURST.

Function
REQ-015 SHALL implement two states: IDLE and BURST.
REQ-016 In IDLE with any req_valid high and fifo_full low, SHALL select the first requester with valid high searching from (last_grant+1) mod NUM_REQ upward with wrap-around, register it into grant_id and move to BURST at the next edge.
REQ-017 In IDLE, req_ready SHALL be all-zero and no beat SHALL be accepted (one-cycle arbitration bubble).
REQ-018 In BURST, req_ready[grant_id] SHALL equal ~fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 fifo_wrreq SHALL equal busy & req_valid[grant_id] & ~fifo_full, combinationally (zero latency); fifo_data SHALL equal req_data slice of grant_id.
REQ-020 An 8-bit beat counter SHALL clear on entry to BURST and increment on each accepted beat.
REQ-021 BURST SHALL return to IDLE after the edge that accepts beat number MAX_BURST, or on any edge where req_valid[grant_id] is low; last_grant SHALL be set to grant_id on exit.
REQ-022 fifo_full high in BURST SHALL stall (stay in BURST, counter held) without ending the burst.
REQ-023 Never SHALL fifo_wrreq assert while fifo_full is high.
REQ-024 A valid dropped by a non-granted requester SHALL have no effect.

Reset
REQ-025 aclr high SHALL immediately force state IDLE, grant_id 0, last_grant NUM_REQ-1, beat counter 0, busy 0; req_ready 0 and fifo_wrreq 0 follow combinationally.
REQ-026 sclr high at an edge SHALL apply the same values synchronously, overriding any beat acceptance in that cycle (fifo_wrreq forced 0 while sclr high).
REQ-027 Reset mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-028 Macro FIFO_WR_ARB_CNT_EN defined: SHALL add output beat_cnt, NUM_REQ*16 bits, per-requester 16-bit count of accepted beats, saturating at 65535, cleared by aclr/sclr.
REQ-029 Macro FIFO_WR_ARB_CNT_EN undefined: port beat_cnt and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single requester: req_valid=4'b0001 for 6 beats, MAX_BURST=4, fifo_full=0 -> beats 1-4 written, 1 IDLE bubble, beats 5-6 written; grant_id=0 throughout.
REQ-031 Round robin: req_valid=4'b1111 held -> grants in order 0,1,2,3,0, each 4 beats, fifo_wrreq duty 4 of 5 cycles.
REQ-032 Backpressure: fifo_full=1 for 3 cycles at beat 2 of a burst -> req_ready and fifo_wrreq 0 for 3 cycles, burst resumes, exactly 4 beats total, no write while full.
REQ-033 Early drop: requester 2 deasserts valid after 2 beats -> return to IDLE, next grant to requester 3 if valid.
REQ-034 aclr pulse mid-burst (beat 3 of requester 1) -> busy, req_ready, fifo_wrreq 0 same cycle; next grant goes to requester 0.
REQ-035 With FIFO_WR_ARB_CNT_EN: 10 beats from requester 3 -> beat_cnt[63:48]=10, others 0; sclr -> all 0.
